// File: rtl/cpu_mem_pkg.sv
// Types and default widths shared by the I/D memory-port arbiter and the memory model.
package cpu_mem_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_RD = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_e;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and memory stage (D); D has priority,
// bounded by a streak counter so a pending fetch is granted after D_STREAK_MAX D grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = cpu_mem_pkg::ADDR_W,
  parameter int DATA_W       = cpu_mem_pkg::DATA_W,
  parameter int D_STREAK_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_f,
  output logic                stall_m
);
  import cpu_mem_pkg::*;

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STREAK_MAX = 4'(D_STREAK_MAX);

  arb_state_e          state_q, state_d;
  logic                owner_q, owner_d;
  logic [3:0]          streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

  logic i_starved;
  assign i_starved = i_req && (streak_q == STREAK_MAX);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (d_req && !i_starved) begin
          owner_d     = OWN_D;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_we ? d_be : '1;
          state_d     = ARB_ISSUE;
          if (i_req && streak_q != STREAK_MAX) streak_d = streak_q + 4'd1;
        end else if (i_req) begin
          owner_d     = OWN_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_be_d    = '1;
          state_d     = ARB_ISSUE;
          streak_d    = '0;
        end
      end
      ARB_ISSUE: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? ARB_RESP : ARB_WAIT_RD;
        end
      end
      ARB_WAIT_RD: begin
        if (mem_rvalid) begin
          if (owner_q == OWN_D) d_rdata_d = mem_rdata;
          else                  i_rdata_d = mem_rdata;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
    // A cycle without a pending fetch ends any D streak.
    if (!i_req) streak_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_I;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

  // Done is decoded from registered state, so it is a clean single-cycle pulse.
  assign i_done  = (state_q == ARB_RESP) && (owner_q == OWN_I);
  assign d_done  = (state_q == ARB_RESP) && (owner_q == OWN_D);
  assign stall_f = i_req && !i_done;
  assign stall_m = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction model.
module tb_mem_port_arbiter;

  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        i_done, d_done, mem_req, mem_we, stall_f, stall_m;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem    [16];
  logic [31:0] refmem [16];
  logic [31:0] last_i = '0, last_d = '0;

  bit auto_mem = 1'b0;
  int rdy_lo = 0, rdy_hi = 0, rv_lo = 0, rv_hi = 0;
  int rdy_cnt = 0, rv_cnt = 0;
  bit rd_pend = 1'b0;
  int rd_idx = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .D_STREAK_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  // Memory responder: programmable ready and read-data wait states, acts 1ns after each edge.
  always @(posedge clk) begin
    #1;
    if (auto_mem) begin
      mem_rvalid = 1'b0;
      if (rd_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[rd_idx];
          rd_pend    = 1'b0;
        end else rv_cnt--;
      end
      mem_ready = 1'b0;
      if (!mem_req) rdy_cnt = $urandom_range(rdy_hi, rdy_lo);
      else if (rdy_cnt != 0) rdy_cnt--;
      else begin
        mem_ready = 1'b1;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end else begin
          rd_pend = 1'b1;
          rd_idx  = int'(mem_addr[5:2]);
          rv_cnt  = $urandom_range(rv_hi, rv_lo);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, i_done, d_done} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {mem_req, mem_we, i_done, d_done});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be} !== 68'h0) begin
      errors++; $display("FAIL reset_cmd got %h %h %h exp 0", mem_addr, mem_wdata, mem_be);
    end
    checks++;
    if ({i_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got %h %h exp 0", i_rdata, d_rdata);
    end
    i_req = 1'b1; d_req = 1'b1;
    #1;
    checks++;
    if ({stall_f, stall_m, mem_req} !== 3'b110) begin
      errors++; $display("FAIL reset_stall got %b exp 110", {stall_f, stall_m, mem_req});
    end
    i_req = 1'b0; d_req = 1'b0;
    #1;
    reset = 1'b1;
    step();
  endtask

  task automatic test_i_read();
    mem[4] = 32'h0050_0093; refmem[4] = 32'h0050_0093;
    rdy_lo = 0; rdy_hi = 0; rv_lo = 0; rv_hi = 0;
    auto_mem = 1'b1;
    step();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, i_done, stall_f} !== {c == 1, c == 3, c < 3}) begin
        errors++; $display("FAIL iread_c%0d req/done/stall got %b exp %b", c,
                           {mem_req, i_done, stall_f}, {c == 1, c == 3, c < 3});
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_addr, mem_be} !== {1'b0, 32'h10, 4'hF}) begin
          errors++; $display("FAIL iread_cmd got %b %h %h exp 0 00000010 f", mem_we, mem_addr, mem_be);
        end
      end
      if (c == 3) begin
        checks++;
        if (i_rdata !== 32'h0050_0093) begin
          errors++; $display("FAIL iread_data got %h exp 00500093", i_rdata);
        end
      end
      step();
      if (c == 3) i_req = 1'b0;
    end
    last_i = 32'h0050_0093;
  endtask

  task automatic test_d_store_vs_i();
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    i_req = 1'b1; i_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, d_done, i_done, stall_m, stall_f} !==
          {c == 1 || c == 4, c == 2, c == 6, c < 2, c < 6}) begin
        errors++; $display("FAIL dvi_c%0d req/dd/id/sm/sf got %b exp %b", c,
                           {mem_req, d_done, i_done, stall_m, stall_f},
                           {c == 1 || c == 4, c == 2, c == 6, c < 2, c < 6});
      end
      if (c == 1) begin
        checks++;
        if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF}) begin
          errors++; $display("FAIL dvi_dcmd got %b %h %h %h", mem_we, mem_be, mem_addr, mem_wdata);
        end
      end
      if (c == 4) begin
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 32'h10}) begin
          errors++; $display("FAIL dvi_icmd got %b %h exp 0 00000010", mem_we, mem_addr);
        end
      end
      if (c == 6) begin
        checks++;
        if ({i_rdata, d_rdata} !== {32'h0050_0093, last_d}) begin
          errors++; $display("FAIL dvi_rdata got %h %h exp 00500093 %h", i_rdata, d_rdata, last_d);
        end
      end
      step();
      if (c == 2) d_req = 1'b0;
      if (c == 6) i_req = 1'b0;
    end
    refmem[0] = 32'hDEAD_BEEF;
  endtask

  task automatic test_wait_states();
    rdy_lo = 3; rdy_hi = 3; rv_lo = 1; rv_hi = 1;
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'h3;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, d_done, stall_m} !== {c >= 1 && c <= 4, c == 7, c < 7}) begin
        errors++; $display("FAIL wait_c%0d req/done/stall got %b exp %b", c,
                           {mem_req, d_done, stall_m}, {c >= 1 && c <= 4, c == 7, c < 7});
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if ({mem_we, mem_addr, mem_be} !== {1'b0, 32'h100, 4'hF}) begin
          errors++; $display("FAIL wait_cmd_c%0d got %b %h %h exp 0 00000100 f", c, mem_we, mem_addr, mem_be);
        end
      end
      if (c == 7) begin
        checks++;
        if (d_rdata !== refmem[0]) begin
          errors++; $display("FAIL wait_data got %h exp %h", d_rdata, refmem[0]);
        end
      end
      step();
      if (c == 7) d_req = 1'b0;
    end
    last_d = refmem[0];
    rdy_lo = 0; rdy_hi = 0; rv_lo = 0; rv_hi = 0;
  endtask

  task automatic test_starvation();
    bit grants[$];
    bit prev_req = 1'b0;
    bit drained = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h104; d_wdata = 32'h1234_5678; d_be = 4'hF;
    i_req = 1'b1; i_addr = 32'h14;
    for (int c = 0; c < 200 && !drained; c++) begin
      @(negedge clk);
      if (mem_req && !prev_req && grants.size() < 10) grants.push_back(mem_we);
      prev_req = mem_req;
      if (grants.size() == 10 && !mem_req && (i_done || d_done)) drained = 1'b1;
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (grants.size() != 10 || !drained) begin
      errors++; $display("FAIL starve_timeout got %0d grants exp 10", grants.size());
    end
    for (int k = 0; k < grants.size(); k++) begin
      checks++;
      if (grants[k] !== (k % 5 != 4)) begin
        errors++; $display("FAIL starve_order_%0d got %s exp %s", k,
                           grants[k] ? "D" : "I", (k % 5 != 4) ? "D" : "I");
      end
    end
    refmem[1] = 32'h1234_5678;
    last_i = refmem[5];
    repeat (2) step();
  endtask

  task automatic test_spurious_reset();
    auto_mem = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, i_done, d_done, i_rdata, d_rdata} !== {3'b000, last_i, last_d}) begin
        errors++; $display("FAIL spurious_c%0d got %b %h %h exp 000 %h %h", c,
                           {mem_req, i_done, d_done}, i_rdata, d_rdata, last_i, last_d);
      end
      step();
      mem_rvalid = 1'b0; mem_ready = 1'b0;
    end
    // Read stalls in WAIT_RD long enough for reset to land before the data returns.
    rv_lo = 5; rv_hi = 5;
    auto_mem = 1'b1;
    i_req = 1'b1; i_addr = 32'h18;
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b0; i_req = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, i_done, d_done, mem_addr, mem_wdata, mem_be, i_rdata, d_rdata} !== 136'h0) begin
      errors++; $display("FAIL rst_async got %b %h %h %h %h %h", {mem_req, mem_we, i_done, d_done},
                         mem_addr, mem_wdata, mem_be, i_rdata, d_rdata);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    last_i = '0; last_d = '0;
    for (int c = 0; c < 8; c++) begin
      step();
      @(negedge clk);
      checks++;
      if ({mem_req, i_done, d_done, i_rdata} !== {3'b000, 32'h0}) begin
        errors++; $display("FAIL late_rvalid_c%0d got %b %h exp 000 0", c, {mem_req, i_done, d_done}, i_rdata);
      end
    end
    rv_lo = 0; rv_hi = 0;
    step();
    i_req = 1'b1; i_addr = 32'h18;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, i_done} !== {c == 1, c == 3}) begin
        errors++; $display("FAIL post_rst_c%0d got %b exp %b", c, {mem_req, i_done}, {c == 1, c == 3});
      end
      if (c == 3) begin
        checks++;
        if (i_rdata !== refmem[6]) begin
          errors++; $display("FAIL post_rst_data got %h exp %h", i_rdata, refmem[6]);
        end
      end
      step();
      if (c == 3) i_req = 1'b0;
    end
    last_i = refmem[6];
  endtask

  // Random traffic: the model tracks the outstanding transaction and grant rules directly.
  task automatic test_random();
    bit m_cmd = 0, m_own = 0, m_we = 0, m_wait = 0, m_di = 0, m_dd = 0, ndi, ndd, free;
    logic [31:0] m_addr = '0, m_wdata = '0;
    logic [3:0]  m_be = '0, m_idx = '0;
    int streak = 0;
    bit seen_i, seen_d;
    rdy_lo = 0; rdy_hi = 2; rv_lo = 0; rv_hi = 2;
    step();
    for (int cyc = 0; cyc < 700; cyc++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== m_cmd) begin
        errors++; $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, mem_req, m_cmd);
      end
      if (m_cmd) begin
        checks++;
        if ({mem_we, mem_addr, mem_be} !== {m_we, m_addr, m_be} || (m_we && mem_wdata !== m_wdata)) begin
          errors++; $display("FAIL rnd_cmd cyc %0d got %b %h %h %h exp %b %h %h %h", cyc,
                             mem_we, mem_addr, mem_be, mem_wdata, m_we, m_addr, m_be, m_wdata);
        end
      end
      checks++;
      if ({i_done, d_done} !== {m_di, m_dd}) begin
        errors++; $display("FAIL rnd_done cyc %0d got %b exp %b", cyc, {i_done, d_done}, {m_di, m_dd});
      end
      checks++;
      if (i_rdata !== last_i || d_rdata !== last_d) begin
        errors++; $display("FAIL rnd_rdata cyc %0d got %h %h exp %h %h", cyc, i_rdata, d_rdata, last_i, last_d);
      end
      checks++;
      if ({stall_f, stall_m} !== {i_req && !m_di, d_req && !m_dd}) begin
        errors++; $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, {stall_f, stall_m},
                           {i_req && !m_di, d_req && !m_dd});
      end
      free = !m_cmd && !m_wait && !m_di && !m_dd;
      ndi = 0; ndd = 0;
      if (m_cmd && mem_ready) begin
        m_cmd = 0;
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) refmem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
          ndd = 1;
        end else begin
          m_wait = 1; m_idx = m_addr[5:2];
        end
      end else if (m_wait && mem_rvalid) begin
        m_wait = 0;
        if (m_own) begin ndd = 1; last_d = refmem[m_idx]; end
        else       begin ndi = 1; last_i = refmem[m_idx]; end
      end
      if (free) begin
        if (d_req && !(i_req && streak == SMAX)) begin
          m_cmd = 1; m_own = 1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
          m_be = d_we ? d_be : 4'hF;
          if (i_req && streak < SMAX) streak++;
        end else if (i_req) begin
          m_cmd = 1; m_own = 0; m_we = 0; m_addr = i_addr; m_be = 4'hF;
          streak = 0;
        end
      end
      if (!i_req) streak = 0;
      m_di = ndi; m_dd = ndd;
      seen_i = i_done; seen_d = d_done;
      step();
      if (i_req) begin
        if (seen_i) begin
          if (cyc < 600 && $urandom_range(0, 1) == 1) i_addr = $urandom & 32'h0000_FFFC;
          else i_req = 1'b0;
        end
      end else if (cyc < 600 && $urandom_range(0, 9) < 4) begin
        i_req = 1'b1; i_addr = $urandom & 32'h0000_FFFC;
      end
      if (d_req) begin
        if (seen_d) begin
          if (cyc < 600 && $urandom_range(0, 1) == 1) begin
            d_we = 1'($urandom); d_addr = $urandom & 32'h0000_FFFC;
            d_wdata = $urandom; d_be = 4'($urandom);
          end else d_req = 1'b0;
        end
      end else if (cyc < 600 && $urandom_range(0, 9) < 4) begin
        d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom & 32'h0000_FFFC;
        d_wdata = $urandom; d_be = 4'($urandom);
      end
    end
    checks++;
    if (m_cmd || m_wait || i_req || d_req) begin
      errors++; $display("FAIL rnd_drain got busy %b exp idle", {m_cmd, m_wait, i_req, d_req});
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      mem[k]    = 32'hA5A5_0000 | k;
      refmem[k] = 32'hA5A5_0000 | k;
    end
    test_reset();
    test_i_read();
    test_d_store_vs_i();
    test_wait_states();
    test_starvation();
    test_spurious_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch stage (I-side) and the memory stage (D-side) of the 5-stage pipelined RV32I core.
- Arbitrates requests and registers the winner's command onto the memory port.
- Tracks the single outstanding transaction, returns read data to the correct requester, and produces the stall_f and stall_m inputs for the hazard unit.
- D-side has priority, with a bounded-streak guard so that fetch cannot starve.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port.
- DATA_W, 32, data width.
- D_STREAK_MAX, 4, maximum consecutive D grants while i_req is pending before I is forced a grant (range 1..15).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch read request; held with i_addr until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_done  out  1  one-cycle pulse: i_rdata valid.
- i_rdata  out  DATA_W  registered instruction word.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  DATA_W/8  store byte enables.
- d_done  out  1  one-cycle pulse: store accepted or load data valid.
- d_rdata  out  DATA_W  registered load data.
- mem_req  out  1  command valid; held until mem_ready.
- mem_we  out  1  command is a write.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  DATA_W/8  write byte enables (all ones for reads).
- mem_ready  in  1  memory accepts the command this cycle.
- mem_rvalid  in  1  read data valid on mem_rdata.
- mem_rdata  in  DATA_W  read data.
- stall_f  out  1  fetch must hold: i_req && !i_done.
- stall_m  out  1  memory stage must hold: d_req && !d_done.

Behaviour:
- Reset: state=IDLE; owner=I; streak=0. mem_req, mem_we, i_done, d_done = 0. mem_addr, mem_wdata, mem_be, i_rdata, d_rdata = 0. stall_* follow their combinational equations.
- FSM has four states: IDLE, ISSUE, WAIT_RD, RESP. At most one transaction is outstanding.
- IDLE:
  - If d_req && !(i_req && streak==D_STREAK_MAX): grant D.
  - Else if i_req: grant I.
  - On a grant, register the command fields onto the mem_* outputs, record owner, set mem_req=1, go to ISSUE.
  - Nothing requested: stay in IDLE.
- ISSUE:
  - mem_req held with stable fields until mem_ready.
  - On mem_ready, drop mem_req. Write goes to RESP; read goes to WAIT_RD.
  - A read may not accept and return in the same cycle.
- WAIT_RD: on mem_rvalid, capture mem_rdata into the owner's rdata register and go to RESP.
- RESP:
  - Owner's done = 1 for exactly this cycle; then go to IDLE.
  - No arbitration happens in RESP, so a requester's stale req in its done cycle is never re-granted.
- Streak counter:
  - Increment (saturating at D_STREAK_MAX) on each D grant while i_req=1.
  - Clear on any I grant, or in any cycle where i_req=0.
- Latency (zero-wait memory):
  - Read: req sampled in IDLE at cycle 0, done at cycle 3.
  - Write: req sampled at cycle 0, done at cycle 2.
  - Each extra cycle of mem_ready or mem_rvalid wait adds one cycle.
- Non-owner rdata and done are unchanged while the other requester is served.
- mem_rvalid outside WAIT_RD is ignored: no capture, no state change.
- mem_ready outside ISSUE is ignored.
- Simultaneous i_req and d_req in IDLE: D wins unless the streak is saturated with I pending.
- Requester deasserting req mid-transaction is illegal; the transaction still completes and done still pulses.
- Reset mid-transaction: immediate return to IDLE, all outputs cleared. An in-flight mem_rvalid after reset release is ignored (state is IDLE).
- d_be is forwarded only for writes; reads drive all-ones.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - state enum ARB_IDLE/ARB_ISSUE/ARB_WAIT_RD/ARB_RESP (2-bit);
  - owner constants OWN_I=0, OWN_D=1;
  - default widths ADDR_W/DATA_W, shared with the memory model.
- No sub-module. FSM, command register and streak counter stay in one module of roughly 150-200 lines.

Test Plan:
- I-only read, zero-wait memory: i_req, i_addr=0x0000_0010, mem_rdata=0x0050_0093 → mem_req at cycle 1, i_done at cycle 3, i_rdata=0x0050_0093, stall_f=1 during cycles 0-2.
- D store vs. simultaneous I read: d_req/d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF, d_be=0xF, plus i_req → D issued first (mem_we=1, mem_be=0xF), d_done at cycle 2; I issued at cycle 3, i_done at cycle 6.
- Wait states: mem_ready held low 3 cycles, mem_rvalid 2 cycles after acceptance → mem_req/mem_addr stable throughout, d_done 7 cycles after request, d_rdata matches mem_rdata.
- Starvation guard, D_STREAK_MAX=4: continuous d_req and i_req → grant order D,D,D,D,I,D,...; streak resets after the I grant.
- Spurious and reset: mem_rvalid pulsed in IDLE → no done, no capture. reset asserted in WAIT_RD → all outputs 0 asynchronously; after release, a late mem_rvalid is ignored and a new i_req completes normally.
